// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: slave-mode I2S transmitter.
// Follows the DAC-sourced bclk/lrclk, requests one stereo pair per frame over a
// valid/ready handshake and shifts it out MSB-first with the I2S one-bit delay.
module i2s_tx_ctrl #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bclk_in,
  input  logic                    lrclk_in,
  output logic                    sdata_out,
  output logic                    smp_req,
  input  logic                    smp_valid,
  input  logic [SAMPLE_WIDTH-1:0] smp_l,
  input  logic [SAMPLE_WIDTH-1:0] smp_r,
  output logic                    underrun,
  output logic                    framing_err
);

  localparam int             CNT_W    = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Synchronizer chains and edge-detect history
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrclk_sync_q;
  logic                   bclk_prev_q;

  // Frame state
  state_e                  state_q,       state_d;
  logic [SLOT_WIDTH-1:0]   shreg_q,       shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q,     bit_cnt_d;
  logic                    lr_prev_q,     lr_prev_d;
  logic                    sdata_q,       sdata_d;
  logic                    underrun_q,    underrun_d;
  logic                    framing_err_q, framing_err_d;

  // Pair buffer and right-channel holding register
  logic                    pair_full_q,   pair_full_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q,       buf_l_d;
  logic [SAMPLE_WIDTH-1:0] buf_r_q,       buf_r_d;
  logic [SAMPLE_WIDTH-1:0] r_hold_q,      r_hold_d;

  logic fall;
  logic lr;

  // Place a sample in the top bits of a slot word, zero-padding the tail.
  function automatic logic [SLOT_WIDTH-1:0] slot_word(input logic [SAMPLE_WIDTH-1:0] s);
    logic [SLOT_WIDTH-1:0] w;
    w = '0;
    w[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = s;
    return w;
  endfunction

  // Bring bclk and lrclk into the clk domain through identical chains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      bclk_sync_q[0]  <= bclk_in;
      lrclk_sync_q[0] <= lrclk_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sync_q[i]  <= bclk_sync_q[i-1];
        lrclk_sync_q[i] <= lrclk_sync_q[i-1];
      end
      bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = bclk_prev_q & ~bclk_sync_q[SYNC_STAGES-1];
  assign lr   = lrclk_sync_q[SYNC_STAGES-1];

  // Next-state: handshake capture, slot reload on LR transitions, shifting
  always_comb begin
    // NOTE: every _d gets a default first, so no path through this block leaves a latch.
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    lr_prev_d     = lr_prev_q;
    sdata_d       = sdata_q;
    underrun_d    = 1'b0;
    framing_err_d = 1'b0;
    pair_full_d   = pair_full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    r_hold_d      = r_hold_q;

    // Capture a pair whenever the buffer is empty; a full buffer ignores valid.
    if (smp_valid && !pair_full_q) begin
      buf_l_d     = smp_l;
      buf_r_d     = smp_r;
      pair_full_d = 1'b1;
    end

    if (fall) begin
      lr_prev_d = lr;
      sdata_d   = shreg_q[SLOT_WIDTH-1];
      if (lr != lr_prev_q) begin
        bit_cnt_d = '0;
        if (!lr) begin
          // Left start: uses the pre-capture pair_full, so a same-cycle valid underruns.
          if (pair_full_q) begin
            shreg_d     = slot_word(buf_l_q);
            r_hold_d    = buf_r_q;
            pair_full_d = 1'b0;
          end else begin
            shreg_d    = '0;
            r_hold_d   = '0;
            underrun_d = 1'b1;
          end
          state_d = RUN;
        end else begin
          // Right start: idle keeps the shifter silent until the first left start.
          shreg_d = (state_q == RUN) ? slot_word(r_hold_q) : '0;
        end
        if (state_q == RUN && bit_cnt_q != LAST_BIT) begin
          framing_err_d = 1'b1;
        end
      end else begin
        shreg_d = (state_q == RUN) ? (shreg_q << 1) : '0;
        if (bit_cnt_q != LAST_BIT) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Register all frame, buffer and output state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      lr_prev_q     <= 1'b0;
      sdata_q       <= 1'b0;
      underrun_q    <= 1'b0;
      framing_err_q <= 1'b0;
      pair_full_q   <= 1'b0;
      // NOTE: the pair buffer is a few flops rather than a RAM, so it is reset like other state.
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      r_hold_q      <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      lr_prev_q     <= lr_prev_d;
      sdata_q       <= sdata_d;
      underrun_q    <= underrun_d;
      framing_err_q <= framing_err_d;
      pair_full_q   <= pair_full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      r_hold_q      <= r_hold_d;
    end
  end

  assign sdata_out   = sdata_q;
  assign smp_req     = ~pair_full_q;
  assign underrun    = underrun_q;
  assign framing_err = framing_err_q;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// tb_i2s_tx_ctrl: directed + randomized bench for i2s_tx_ctrl.
// The reference model tracks frames as bit queues and slot lengths in bclk falls.
module tb_i2s_tx_ctrl;

  localparam int SW = 16;
  localparam int SL = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          bclk_in;
  logic          lrclk_in;
  logic          sdata_out;
  logic          smp_req;
  logic          smp_valid;
  logic [SW-1:0] smp_l;
  logic [SW-1:0] smp_r;
  logic          underrun;
  logic          framing_err;

  i2s_tx_ctrl #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bclk_in     (bclk_in),
    .lrclk_in    (lrclk_in),
    .sdata_out   (sdata_out),
    .smp_req     (smp_req),
    .smp_valid   (smp_valid),
    .smp_l       (smp_l),
    .smp_r       (smp_r),
    .underrun    (underrun),
    .framing_err (framing_err)
  );

  always #10 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Pulse counters
  int ur_cnt = 0;
  int fe_cnt = 0;
  always @(posedge clk) begin
    if (underrun === 1'b1)    ur_cnt++;
    if (framing_err === 1'b1) fe_cnt++;
  end

  // Reference model state
  bit          m_bits[$];
  logic [15:0] m_l, m_r, m_hold, held_l, held_r;
  logic        m_full, m_run, m_lr_prev, valid_held;
  int          m_slot_len;
  logic [31:0] obs_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    m_full = 1'b0; m_run = 1'b0; m_lr_prev = 1'b0;
    m_hold = '0; m_l = '0; m_r = '0; m_slot_len = 0;
  endfunction

  function automatic void push_sample(input logic [15:0] s);
    for (int i = SW - 1; i >= 0; i--) m_bits.push_back(s[i]);
    for (int i = 0; i < SL - SW; i++) m_bits.push_back(1'b0);
  endfunction

  // One bclk fall: the bit that leaves now, plus expected pulse counts.
  function automatic void model_fall(input logic lr, output logic b, output int ur, output int fe);
    b  = (m_bits.size() > 0) ? m_bits.pop_front() : 1'b0;
    ur = 0;
    fe = 0;
    m_slot_len++;
    if (lr != m_lr_prev) begin
      if (m_run && m_slot_len != SL) fe = 1;
      m_slot_len = 0;
      m_bits.delete();
      if (!lr) begin
        if (m_full) begin
          push_sample(m_l);
          m_hold = m_r;
          m_full = 1'b0;
        end else begin
          m_hold = '0;
          ur     = 1;
        end
        m_run = 1'b1;
        if (valid_held) begin
          m_l = held_l; m_r = held_r; m_full = 1'b1;
        end
      end else if (m_run) begin
        push_sample(m_hold);
      end
    end
    m_lr_prev = lr;
  endfunction

  // One full bclk period (16 clk low, ~17 clk high) starting with a fall.
  task automatic bclk_cycle(input logic lr);
    logic eb;
    int   eu, ef, ur0, fe0;
    @(negedge clk);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    model_fall(lr, eb, eu, ef);
    ur0 = ur_cnt;
    fe0 = fe_cnt;
    repeat (8) @(negedge clk);
    check("sdata",       {31'b0, sdata_out}, {31'b0, eb});
    check("underrun",    32'(ur_cnt - ur0),  32'(eu));
    check("framing_err", 32'(fe_cnt - fe0),  32'(ef));
    check("smp_req",     {31'b0, smp_req},   {31'b0, ~m_full});
    obs_word = {obs_word[30:0], sdata_out};
    repeat (8) @(negedge clk);
    bclk_in = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic run_slot(input logic lr, input int n);
    for (int i = 0; i < n; i++) bclk_cycle(lr);
  endtask

  task automatic give_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    smp_l = l; smp_r = r; smp_valid = 1'b1;
    if (!m_full) begin
      m_l = l; m_r = r; m_full = 1'b1;
    end
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  int ur0, fe0;

  initial begin
    reset = 1'b1; bclk_in = 1'b1; lrclk_in = 1'b1;
    smp_valid = 1'b0; smp_l = '0; smp_r = '0;
    valid_held = 1'b0; held_l = '0; held_r = '0;
    model_reset();

    // 1: reset state with clocks idle
    repeat (5) @(negedge clk);
    check("rst_sdata",    {31'b0, sdata_out},   32'd0);
    check("rst_smp_req",  {31'b0, smp_req},     32'd1);
    check("rst_underrun", {31'b0, underrun},    32'd0);
    check("rst_framing",  {31'b0, framing_err}, 32'd0);
    reset = 1'b0;
    run_slot(1'b1, 4);

    // 2: pair ahead of the first left start
    give_pair(16'hA5F0, 16'h0F0F);
    repeat (3) @(negedge clk);
    check("t2_req_low", {31'b0, smp_req}, 32'd0);
    run_slot(1'b1, 2);
    run_slot(1'b0, 32);
    bclk_cycle(1'b1);
    check("t2_left_word", obs_word, 32'hA5F0_0000);
    run_slot(1'b1, 31);

    // 3: no pair -> silent frame, one underrun
    ur0 = ur_cnt;
    bclk_cycle(1'b0);
    check("t2_right_word", obs_word, 32'h0F0F_0000);
    run_slot(1'b0, 31);
    run_slot(1'b1, 32);
    check("t3_underruns", 32'(ur_cnt - ur0), 32'd1);
    check("t3_silent",    obs_word,          32'd0);

    // Randomized frames, pairs offered mid right slot
    for (int f = 0; f < 6; f++) begin
      run_slot(1'b0, 32);
      run_slot(1'b1, 16);
      if ($urandom_range(0, 3) != 0) give_pair(16'($urandom), 16'($urandom));
      run_slot(1'b1, 16);
    end

    // 4: short left slot -> one framing error, right MSB still on the next fall
    give_pair(16'hAAAA, 16'h8001);
    fe0 = fe_cnt;
    run_slot(1'b0, 20);
    bclk_cycle(1'b1);
    bclk_cycle(1'b1);
    check("t4_framing_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("t4_right_msb",      {31'b0, obs_word[0]}, 32'd1);
    run_slot(1'b1, 30);

    // 5: valid held while the buffer is full
    give_pair(16'h1234, 16'h5678);
    @(negedge clk);
    held_l = 16'h9ABC; held_r = 16'hDEF0;
    smp_l = held_l; smp_r = held_r; smp_valid = 1'b1; valid_held = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_req_low", {31'b0, smp_req}, 32'd0);
    bclk_cycle(1'b0);
    smp_valid = 1'b0; valid_held = 1'b0;
    run_slot(1'b0, 31);
    bclk_cycle(1'b1);
    check("t5_left_first", obs_word, 32'h1234_0000);
    run_slot(1'b1, 31);
    bclk_cycle(1'b0);
    check("t5_right_first", obs_word, 32'h5678_0000);
    run_slot(1'b0, 31);
    bclk_cycle(1'b1);
    check("t5_left_second", obs_word, 32'h9ABC_0000);
    run_slot(1'b1, 31);

    // 6: reset mid left slot
    give_pair(16'hFFFF, 16'h0000);
    bclk_cycle(1'b0);
    run_slot(1'b0, 4);
    give_pair(16'h1111, 16'h2222);
    bclk_cycle(1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6_sdata",    {31'b0, sdata_out},   32'd0);
    check("t6_smp_req",  {31'b0, smp_req},     32'd1);
    check("t6_underrun", {31'b0, underrun},    32'd0);
    check("t6_framing",  {31'b0, framing_err}, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ur0 = ur_cnt;
    fe0 = fe_cnt;
    run_slot(1'b0, 26);
    run_slot(1'b1, 32);
    check("t6_no_framing", 32'(fe_cnt - fe0), 32'd0);
    check("t6_no_underrun", 32'(ur_cnt - ur0), 32'd0);
    give_pair(16'hC3C3, 16'h3C3C);
    run_slot(1'b0, 32);
    bclk_cycle(1'b1);
    check("t6_resume_left", obs_word, 32'hC3C3_0000);
    run_slot(1'b1, 31);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
